// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op encodings and FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_NOP0  = 3'b110,
    MD_NOP1  = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } md_state_t;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step on unsigned magnitudes.
// The next dividend bit is taken from the top of quot_in, and the new
// quotient bit is shifted in at the bottom.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Trial-subtract the divisor from the shifted remainder and keep the result only when it does not go negative.
  // The difference fits in WIDTH bits whenever it is kept, because the remainder is then smaller than the divisor.
  always_comb begin
    shifted = {rem_in, quot_in[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_out  = diff;
      quot_out = {quot_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out  = shifted[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit that owns the architectural HI/LO registers.
// Signed ops work on magnitudes and fix the signs in a final cycle.
// The same 2*WIDTH accumulator serves as the product for multiply and as {remainder, quotient} for divide.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

  md_state_t          state, state_nxt;
  md_op_t             op_sel;
  logic               accept, is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag_in, b_mag, cnt;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_step, quot_step, quot_fix, rem_fix;
  logic               neg_main, neg_rem, op_div;

  assign op_sel = md_op_t'(op);
  assign accept = start && (state == IDLE);

  // Decode the request and reduce signed operands to unsigned magnitudes (the most-negative value maps to 2^(W-1)).
  always_comb begin
    is_signed = (op_sel == MD_MULT) || (op_sel == MD_DIV);
    is_div    = (op_sel == MD_DIV) || (op_sel == MD_DIVU);
    a_neg     = is_signed && rs_val[WIDTH-1];
    b_neg     = is_signed && rt_val[WIDTH-1];
    a_mag     = a_neg ? -rs_val : rs_val;
    b_mag_in  = b_neg ? -rt_val : rt_val;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: iterate WIDTH cycles, then spend one cycle on sign fix-up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && (op_sel == MD_MULT || op_sel == MD_MULTU)) state_nxt = MUL;
        else if (accept && is_div)                               state_nxt = DIV;
      end
      MUL, DIV: if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output logic: busy covers the iteration cycles and the fix-up cycle.
  always_comb begin
    busy = (state != IDLE);
  end

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right with the carry.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
  end

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in   (acc[2*WIDTH-1:WIDTH]),
    .quot_in  (acc[WIDTH-1:0]),
    .divisor  (b_mag),
    .rem_out  (rem_step),
    .quot_out (quot_step)
  );

  // Apply the latched result signs to the finished magnitudes.
  always_comb begin
    prod_fix = neg_main ? -acc : acc;
    quot_fix = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Datapath: latch operands on accept, iterate, and commit HI/LO only at the end of the fix-up cycle.
  // A zero divisor leaves the quotient as all ones and the remainder as |rs|, so the quotient sign flip is suppressed
  // and the dividend-sign flip on the remainder restores rs itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      b_mag    <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      op_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op_sel)
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                acc      <= {{WIDTH{1'b0}}, a_mag};
                b_mag    <= b_mag_in;
                cnt      <= '0;
                op_div   <= is_div;
                neg_main <= (a_neg ^ b_neg) && !(is_div && (rt_val == '0));
                neg_rem  <= is_div && a_neg;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= {rem_step, quot_step};
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (op_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases plus randomized ops,
// checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         start  = 1'b0;
  logic [2:0]   op     = 3'b000;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: MIPS HI/LO semantics from plain integer arithmetic.
  // Signed divide truncates toward zero and the remainder follows the dividend.
  // The most-negative / -1 quotient wraps to 0x80000000 when truncated to W bits.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint     sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = mhi;
    el = mlo;
    case (o)
      3'd0: begin p = sa * sb; {eh, el} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
      3'd2: begin
        if (b == '0) begin eh = a; el = '1; end
        else begin el = W'(sa / sb); eh = W'(sa % sb); end
      end
      3'd3: begin
        if (b == '0) begin eh = a; el = '1; end
        else begin el = a / b; eh = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Present one request for a single clock edge; returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run one arithmetic op, count busy cycles, check the result and the done pulse.
  // inject: throw an MTHI and a MULTU at the unit while it is busy.
  // chain: skip the done-fall check so the caller can start again in the done cycle.
  task automatic runArith(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject, input bit chain);
    logic [W-1:0] eh, el;
    int           cycles;
    model(o, a, b, eh, el);
    applyStimulus(o, a, b);
    checkOutput({tag, "_busy_rise"}, W'(busy), W'(1));
    cycles = 0;
    while (busy && cycles < 100) begin
      if (cycles == 16) begin
        checkOutput({tag, "_hi_hold"}, hi, mhi);
        checkOutput({tag, "_lo_hold"}, lo, mlo);
      end
      if (inject && cycles == 4) begin
        start = 1'b1; op = 3'd4; rs_val = ~a; rt_val = ~b;
      end
      if (inject && cycles == 5) begin
        op = 3'd1; rs_val = 32'h0000_0003; rt_val = 32'h0000_0005;
      end
      if (inject && cycles == 6) start = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, "_busy_cycles"}, W'(cycles), W'(W + 1));
    checkOutput({tag, "_done"}, W'(done), W'(1));
    checkOutput({tag, "_hi"}, hi, eh);
    checkOutput({tag, "_lo"}, lo, el);
    mhi = eh;
    mlo = el;
    if (!chain) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_fall"}, W'(done), W'(0));
    end
  endtask

  // Run an MTHI/MTLO/no-op request and confirm it completes without busy or done.
  task automatic runMove(input string tag, input logic [2:0] o, input logic [W-1:0] v);
    applyStimulus(o, v, W'($urandom));
    if (o == 3'd4) mhi = v;
    if (o == 3'd5) mlo = v;
    checkOutput({tag, "_busy"}, W'(busy), W'(0));
    checkOutput({tag, "_done"}, W'(done), W'(0));
    checkOutput({tag, "_hi"}, hi, mhi);
    checkOutput({tag, "_lo"}, lo, mlo);
  endtask

  // Biased operand picker so corner values show up often.
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Main sequence: reset, directed cases, mid-op reset, random ops, summary.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_hi", hi, '0);
    checkOutput("rst_lo", lo, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    runArith("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    checkOutput("multu_max_lo_const", lo, 32'h0000_0001);
    runArith("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
    checkOutput("mult_neg_lo_const", lo, 32'hFFFF_FFF1);
    runArith("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    checkOutput("mult_min_hi_const", hi, 32'h4000_0000);
    runArith("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    checkOutput("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    runArith("divu_zero", 3'd3, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0);
    runArith("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'h0000_0000, 1'b0, 1'b0);
    runArith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("div_ovf_lo_const", lo, 32'h8000_0000);
    runArith("divu_100_7", 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    checkOutput("divu_100_7_lo_const", lo, 32'd14);

    runMove("mtlo", 3'd5, 32'h0000_1234);
    runMove("mthi", 3'd4, 32'hCAFE_0001);
    runMove("nop", 3'd6, 32'hDEAD_BEEF);
    runArith("busy_ignore", 3'd1, 32'h0001_0001, 32'h0000_0100, 1'b1, 1'b0);
    runArith("chain_a", 3'd0, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b1);
    runArith("chain_b", 3'd3, 32'd1000, 32'd33, 1'b0, 1'b0);

    // Asynchronous reset partway through a divide wipes HI/LO immediately.
    applyStimulus(3'd2, 32'd12345, 32'd67);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midrst_busy_before", W'(busy), W'(1));
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", W'(busy), W'(0));
    checkOutput("midrst_done", W'(done), W'(0));
    checkOutput("midrst_hi", hi, '0);
    checkOutput("midrst_lo", lo, '0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    runArith("divu_9_3", 3'd3, 32'd9, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        runMove("rnd_move", 3'($urandom_range(4, 7)), W'($urandom));
      runArith("rnd_arith", 3'($urandom_range(0, 3)), pick(), pick(), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
